mem_load_store_unit: RTL and testbench

- MEM-stage sequencer sitting directly upstream of the 8:1 load-result multiplexer.
- Accepts one load/store from the EX/MEM register and runs a variable-latency data-bus transaction with byte enables.
- Produces eight extended load candidates plus a 3-bit selector (funct3) for the mux, and stalls the pipeline while busy.

---
 rtl/mem_load_store_unit_pkg.sv | 54 +++++
 rtl/mem_load_store_unit_load_extend_unit.sv | 36 +++
 rtl/mem_load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: FSM encoding,
// Funct3 access-size codes, byte-enable patterns and store-formatting helpers.
package mem_load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Undefined size codes are rejected through the same path as misalignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = lane[0];
            F3_W:        bad = (lane != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE << lane;
            2'b01:   be = BE_HALF << {lane[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_store_unit_load_extend_unit.sv
// Combinational lane extraction and sign/zero extension of a returned bus word
// into the eight load-result mux candidates.
module load_extend_unit
    import mem_load_store_unit_pkg::*;
(
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        lane_i,
    output logic [7:0][31:0]  data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword, then form each candidate.
    always_comb begin
        case (lane_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        data_o    = '0;
        data_o[0] = {{24{byte_s[7]}}, byte_s};
        data_o[1] = {{16{half_s[15]}}, half_s};
        data_o[2] = rdata_i;
        data_o[4] = {24'h000000, byte_s};
        data_o[5] = {16'h0000, half_s};
    end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store sequencer: accepts one op, runs a byte-enabled bus
// transaction with timeout, and registers extended load candidates for the mux.
module mem_load_store_unit
    import mem_load_store_unit_pkg::*;
#(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Req_Valid,
    input  logic                 Mem_Read,
    input  logic                 Mem_Write,
    input  logic [2:0]           Funct3,
    input  logic [ADDR_BITS-1:0] Address,
    input  logic [31:0]          Write_Data,
    output logic                 Req_Ready,
    output logic                 Stall,
    output logic                 Bus_Req,
    output logic                 Bus_We,
    output logic [ADDR_BITS-1:0] Bus_Addr,
    output logic [3:0]           Bus_Byte_En,
    output logic [31:0]          Bus_Wdata,
    input  logic                 Bus_Ack,
    input  logic [31:0]          Bus_Rdata,
    output logic [31:0]          Data_0,
    output logic [31:0]          Data_1,
    output logic [31:0]          Data_2,
    output logic [31:0]          Data_3,
    output logic [31:0]          Data_4,
    output logic [31:0]          Data_5,
    output logic [31:0]          Data_6,
    output logic [31:0]          Data_7,
    output logic [2:0]           Selector,
    output logic                 Result_Valid,
    output logic                 Misalign_Error,
    output logic                 Bus_Error
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e              state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [2:0]              f3_q;
    logic                    store_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic                    err_bus_q;
    logic [7:0][31:0]        data_q;
    logic [2:0]              sel_q;

    logic                    accept_s;
    logic                    store_s;
    logic                    misalign_s;
    logic                    load_cap_s;
    logic                    timeout_s;
    logic [7:0][31:0]        ext_s;

    assign accept_s   = (state_q == ST_IDLE) && Req_Valid && (Mem_Read || Mem_Write);
    assign store_s    = Mem_Write && !Mem_Read;
    assign misalign_s = is_misaligned(Funct3, Address[1:0]);

    load_extend_unit u_extend (
        .rdata_i (Bus_Rdata),
        .lane_i  (addr_q[1:0]),
        .data_o  (ext_s)
    );

    // Next-state logic; the wait counter is zeroed on accept and the last
    // ACCESS cycle still honours an ack ahead of the timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_cap_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d = 16'd0;
                    if (misalign_s) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (Bus_Ack) begin
                    state_d    = ST_DONE;
                    load_cap_s = !store_q;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d   = ST_ERR;
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Op capture on accept; byte enables and lane data are formed here so
    // the bus sees them stable for the whole ACCESS phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            f3_q      <= 3'd0;
            store_q   <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            err_bus_q <= 1'b0;
        end else if (accept_s) begin
            addr_q    <= Address;
            f3_q      <= Funct3;
            store_q   <= store_s;
            be_q      <= store_s ? store_byte_en(Funct3, Address[1:0]) : BE_WORD;
            wdata_q   <= store_s ? store_wdata(Funct3, Write_Data) : 32'd0;
            err_bus_q <= 1'b0;
        end else if (timeout_s) begin
            err_bus_q <= 1'b1;
        end
    end

    // Load candidates and selector change only on a successful load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            sel_q  <= 3'd0;
        end else if (load_cap_s) begin
            data_q <= ext_s;
            sel_q  <= f3_q;
        end
    end

    assign Req_Ready      = (state_q == ST_IDLE);
    assign Stall          = accept_s || (state_q == ST_ACCESS) || (state_q == ST_ERR);
    assign Bus_Req        = (state_q == ST_ACCESS);
    assign Bus_We         = (state_q == ST_ACCESS) && store_q;
    assign Bus_Addr       = {addr_q[ADDR_BITS-1:2], 2'b00};
    assign Bus_Byte_En    = be_q;
    assign Bus_Wdata      = wdata_q;
    assign Result_Valid   = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign Misalign_Error = (state_q == ST_ERR) && !err_bus_q;
    assign Bus_Error      = (state_q == ST_ERR) && err_bus_q;

    assign Data_0   = data_q[0];
    assign Data_1   = data_q[1];
    assign Data_2   = data_q[2];
    assign Data_3   = data_q[3];
    assign Data_4   = data_q[4];
    assign Data_5   = data_q[5];
    assign Data_6   = data_q[6];
    assign Data_7   = data_q[7];
    assign Selector = sel_q;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed bench for mem_load_store_unit: a transaction-level model sets the
// expected outputs for each cycle and one process compares them on the falling edge.
module tb_mem_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req_Valid, Mem_Read, Mem_Write;
    logic [2:0]  Funct3;
    logic [31:0] Address, Write_Data;
    logic        Req_Ready, Stall, Bus_Req, Bus_We;
    logic [31:0] Bus_Addr;
    logic [3:0]  Bus_Byte_En;
    logic [31:0] Bus_Wdata;
    logic        Bus_Ack;
    logic [31:0] Bus_Rdata;
    logic [31:0] Data_0, Data_1, Data_2, Data_3, Data_4, Data_5, Data_6, Data_7;
    logic [2:0]  Selector;
    logic        Result_Valid, Misalign_Error, Bus_Error;

    always #5 clk = ~clk;

    mem_load_store_unit #(.ADDR_BITS(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .Req_Valid(Req_Valid), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Funct3(Funct3), .Address(Address), .Write_Data(Write_Data),
        .Req_Ready(Req_Ready), .Stall(Stall), .Bus_Req(Bus_Req), .Bus_We(Bus_We),
        .Bus_Addr(Bus_Addr), .Bus_Byte_En(Bus_Byte_En), .Bus_Wdata(Bus_Wdata),
        .Bus_Ack(Bus_Ack), .Bus_Rdata(Bus_Rdata),
        .Data_0(Data_0), .Data_1(Data_1), .Data_2(Data_2), .Data_3(Data_3),
        .Data_4(Data_4), .Data_5(Data_5), .Data_6(Data_6), .Data_7(Data_7),
        .Selector(Selector), .Result_Valid(Result_Valid),
        .Misalign_Error(Misalign_Error), .Bus_Error(Bus_Error)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected values maintained by the model
    bit          chk_en  = 1'b0;
    bit          chk_bus = 1'b0;
    bit          chk_wd  = 1'b0;
    logic        e_ready, e_stall, e_req, e_we, e_rv, e_mis, e_berr;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic [31:0] m_data [8];
    logic [2:0]  m_sel;
    logic [31:0] d_act [8];

    assign d_act[0] = Data_0; assign d_act[1] = Data_1;
    assign d_act[2] = Data_2; assign d_act[3] = Data_3;
    assign d_act[4] = Data_4; assign d_act[5] = Data_5;
    assign d_act[6] = Data_6; assign d_act[7] = Data_7;

    task automatic set_exp(input logic rdy, stl, req, rv, mis, berr);
        e_ready = rdy; e_stall = stl; e_req = req; e_rv = rv; e_mis = mis; e_berr = berr;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int lo = a % 4;
        logic [3:0] base;
        base = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
        return base << (lo - (lo % sz));
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        if (sz == 1) return (wd & 32'h000000FF) * 32'h01010101;
        if (sz == 2) return (wd & 32'h0000FFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        int lo = a % 4;
        b = (rd >> (8 * lo)) & 32'h000000FF;
        h = (rd >> (16 * (lo / 2))) & 32'h0000FFFF;
        m_data[0] = (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
        m_data[1] = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
        m_data[2] = rd;
        m_data[3] = 32'd0;
        m_data[4] = b;
        m_data[5] = h;
        m_data[6] = 32'd0;
        m_data[7] = 32'd0;
        m_sel     = f3;
    endtask

    // Single compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("Req_Ready", Req_Ready, e_ready);
            check("Stall", Stall, e_stall);
            check("Bus_Req", Bus_Req, e_req);
            check("Bus_We", Bus_We, e_we);
            check("Result_Valid", Result_Valid, e_rv);
            check("Misalign_Error", Misalign_Error, e_mis);
            check("Bus_Error", Bus_Error, e_berr);
            for (int k = 0; k < 8; k++) check($sformatf("Data_%0d", k), d_act[k], m_data[k]);
            check("Selector", Selector, m_sel);
            if (chk_bus) begin
                check("Bus_Addr", Bus_Addr, e_addr);
                check("Bus_Byte_En", Bus_Byte_En, e_be);
            end
            if (chk_wd) check("Bus_Wdata", Bus_Wdata, e_wd);
        end
    end

    // ack_at: ACCESS cycle (1-based) carrying Bus_Ack; 0 means never ack.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata, input bit hold_next);
        bit st = wr && !rd;
        int n;
        Req_Valid = 1'b1; Mem_Read = rd; Mem_Write = wr; Funct3 = f3;
        Address = addr; Write_Data = wd; Bus_Ack = 1'b0;
        set_exp(1, 1, 0, 0, 0, 0); e_we = 1'b0;
        @(posedge clk); #1;
        Req_Valid = 1'b0; Address = ~addr; Funct3 = 3'b011; Write_Data = ~wd;
        if (model_misaligned(f3, addr)) begin
            set_exp(0, 1, 0, 1, 1, 0);
        end else begin
            e_addr = addr & 32'hFFFFFFFC;
            e_be   = st ? model_be(f3, addr) : 4'b1111;
            e_wd   = model_wd(f3, wd);
            e_we   = st;
            chk_bus = 1'b1; chk_wd = st;
            n = (ack_at > 0) ? ack_at : TMO;
            for (int i = 1; i <= n; i++) begin
                set_exp(0, 1, 1, 0, 0, 0);
                Bus_Ack   = (i == ack_at);
                Bus_Rdata = (i == ack_at) ? rdata : 32'h5A5A5A5A;
                @(posedge clk); #1;
            end
            Bus_Ack = 1'b0; chk_bus = 1'b0; chk_wd = 1'b0; e_we = 1'b0;
            if (ack_at > 0) begin
                if (!st) model_load(f3, addr, rdata);
                set_exp(0, 0, 0, 1, 0, 0);
            end else begin
                set_exp(0, 1, 0, 1, 0, 1);
            end
        end
        if (hold_next) begin
            Req_Valid = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b0;
            Funct3 = 3'b010; Address = 32'h00000300;
        end
        @(posedge clk); #1;
        if (!hold_next) begin
            Req_Valid = 1'b0;
            set_exp(1, 0, 0, 0, 0, 0);
            Bus_Ack = 1'b1;
            @(posedge clk); #1;
            Bus_Ack = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; Req_Valid = 1'b0; Mem_Read = 1'b0; Mem_Write = 1'b0;
        Funct3 = 3'd0; Address = 32'd0; Write_Data = 32'd0;
        Bus_Ack = 1'b0; Bus_Rdata = 32'd0;
        for (int k = 0; k < 8; k++) m_data[k] = 32'd0;
        m_sel = 3'd0; e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wd = 32'd0;
        set_exp(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // LW 0x100, ack in third ACCESS cycle
        run_op(1, 0, 3'b010, 32'h00000100, 32'd0, 3, 32'hDEADBEEF, 0);
        check("lit_lw_data2", Data_2, 32'hDEADBEEF);
        check("lit_lw_sel", Selector, 3'b010);

        // LB / LBU at lane 3
        run_op(1, 0, 3'b000, 32'h00000103, 32'd0, 1, 32'h80112233, 0);
        check("lit_lb_data0", Data_0, 32'hFFFFFF80);
        check("lit_lb_data4", Data_4, 32'h00000080);
        run_op(1, 0, 3'b100, 32'h00000103, 32'd0, 2, 32'h80112233, 0);
        check("lit_lbu_sel", Selector, 3'b100);

        // LH upper halfword
        run_op(1, 0, 3'b001, 32'h00000102, 32'd0, 2, 32'h8001CAFE, 0);
        check("lit_lh_data1", Data_1, 32'hFFFF8001);
        check("lit_lh_data5", Data_5, 32'h00008001);

        // Stores: SB lane 1, SH upper, SW; candidates must hold
        run_op(0, 1, 3'b000, 32'h00000201, 32'h000000AB, 1, 32'h0, 0);
        run_op(0, 1, 3'b001, 32'h00000202, 32'h00001234, 2, 32'h0, 0);
        run_op(0, 1, 3'b010, 32'h00000204, 32'h01234567, 1, 32'h0, 0);
        check("lit_store_hold_d1", Data_1, 32'hFFFF8001);
        check("lit_store_hold_sel", Selector, 3'b001);

        // Misaligned and illegal ops; the first holds Req_Valid through ERR
        run_op(1, 0, 3'b010, 32'h00000102, 32'd0, 1, 32'h0, 1);
        run_op(1, 0, 3'b010, 32'h00000300, 32'd0, 1, 32'h11223344, 0);
        run_op(1, 0, 3'b101, 32'h00000101, 32'd0, 1, 32'h0, 0);
        run_op(0, 1, 3'b011, 32'h00000100, 32'd0, 1, 32'h0, 0);

        // Req_Valid during DONE is not accepted
        run_op(1, 0, 3'b101, 32'h00000002, 32'd0, 1, 32'h7FFF1234, 1);
        run_op(1, 0, 3'b010, 32'h00000300, 32'd0, 1, 32'hCAFEF00D, 0);

        // Timeout, ack on the last allowed cycle, Read+Write treated as load
        run_op(1, 0, 3'b010, 32'h00000500, 32'd0, 0, 32'h0, 0);
        run_op(0, 1, 3'b010, 32'h00000504, 32'hFFFFFFFF, 0, 32'h0, 0);
        run_op(1, 0, 3'b000, 32'h00000502, 32'd0, TMO, 32'h00FE0000, 0);
        check("lit_lastack_data0", Data_0, 32'hFFFFFFFE);
        run_op(1, 1, 3'b001, 32'h00000600, 32'h0000BEEF, 1, 32'h0000ABCD, 0);

        // Asynchronous reset in the middle of ACCESS
        chk_en = 1'b0;
        Req_Valid = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b0;
        Funct3 = 3'b010; Address = 32'h00000400;
        @(posedge clk); #1;
        Req_Valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", Bus_Req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_bus_req", Bus_Req, 1'b0);
        check("rst_ready", Req_Ready, 1'b1);
        check("rst_stall", Stall, 1'b0);
        check("rst_data2", Data_2, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) m_data[k] = 32'd0;
        m_sel = 3'd0;
        set_exp(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("post_rst_ready", Req_Ready, 1'b1);
        chk_en = 1'b1;
        run_op(1, 0, 3'b000, 32'h00000101, 32'd0, 1, 32'h00007F00, 0);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
